jtag_dr_stream_ctrl: RTL and testbench
======================================

// Module: jtag_dr_stream_ctrl
// PURPOSE
// Controller between the BSCAN USER4 data register and the puzzle solver datapath.
// Converts 8-bit DR scans (LSB first) into a byte stream, and buffers that stream in a FIFO.
// Presents the bytes to the solver through a valid/ready handshake.
// Captures the solver result into the DR so the host can read it back on tdo.
// PARAMETERS
// RESULT_WIDTH  16  width of solver result; readback word is RESULT_WIDTH+8 bits
// FIFO_DEPTH    16  byte FIFO depth; power of 2, 2..32
// PORTS
// tck               in   1   JTAG TCK, sole clock, rising edge
// test_logic_reset  in   1   async active-high reset (TAP Test-Logic-Reset)
// ir_is_user        in   1   IR holds USER4; gates all DR activity
// capture_dr        in   1   TAP in Capture-DR
// shift_dr          in   1   TAP in Shift-DR
// update_dr         in   1   TAP in Update-DR
// tdi               in   1   serial in, sampled on tck rise while shift_dr
// tdo               out  1   serial out = out_sr[0] (combinational from register)
// byte_data         out  8   FIFO head byte
// byte_valid        out  1   FIFO not empty
// byte_ready        in   1   solver accepts head byte when byte_valid&byte_ready
// result            in   RESULT_WIDTH  solver result
// result_valid      in   1   single-cycle strobe, latches result
// overflow          out  1   sticky: a byte was dropped on full FIFO
// fifo_level        out  6   bytes currently stored
// BEHAVIOUR
// - Reset (async): FSM=IDLE, in_sr=0, bit_cnt=0, out_sr=0, result_q=0, done=0, FIFO empty.
//   All outputs 0 on reset (tdo, byte_valid, byte_data, overflow, fifo_level).
// - Reset asserted mid-scan aborts the scan; the partial byte is discarded.
// - FSM IDLE/SHIFT/COMMIT:
//   - IDLE->SHIFT on capture_dr&ir_is_user: bit_cnt<=0, out_sr<={status,result_q}.
//   - SHIFT: each shift_dr cycle, in_sr<={tdi,in_sr[7:1]}, out_sr<={tdi,out_sr[W-1:1]}.
//     bit_cnt increments, saturating at 255.
//   - SHIFT->COMMIT on update_dr.
//   - COMMIT (1 cycle): push in_sr iff bit_cnt==8, then ->IDLE.
//   - Any other bit_cnt (readback scans) pushes nothing.
// - ir_is_user=0: capture/shift/update are ignored and the FSM is forced to IDLE.
//   The FIFO still drains to the solver.
// - status byte = {overflow, done, fifo_level}. out_sr bits [W-1:RESULT_WIDTH] hold status.
//   A RESULT_WIDTH-bit readback returns the result only.
// - result_valid: result_q<=result, done<=1 on the next edge.
//   A capture on the same edge loads the old result_q.
// - FIFO: push and pop occur on the same edge.
//   - Push when full: accepted only if a pop happens the same cycle.
//     Otherwise the byte is dropped and overflow<=1.
//   - Pop when empty: no effect.
//   - Pointers wrap at FIFO_DEPTH. byte_data is valid the cycle after push (registered level).
// - Latency: the byte is visible on byte_valid 2 tck after the update_dr cycle.
//   That is the COMMIT cycle plus the FIFO write.
// - overflow and done clear only on reset.
// TESTING
// - Scan 0x52 ('R') with byte_ready=1 -> one byte_valid pulse with byte_data=0x52; fifo_level returns to 0.
// - byte_ready=0, scan 17 bytes 0x00..0x10, FIFO_DEPTH=16:
//   fifo_level=16 and overflow=1; popping yields 0x00..0x0F in order.
// - Pulse result_valid with result=0x1234, then do a 16-bit readback scan -> tdo bits LSB first = 0x1234.
//   No byte is pushed.
// - Same state as the previous test, then a 24-bit readback scan -> bits[23:16]=0x40 (done=1, level 0, no overflow).
// - Assert test_logic_reset after 4 shifted bits of 0xFF, then release and scan 0x0A ->
//   only 0x0A is delivered; overflow=0.
// - ir_is_user=0 while scanning 0x33 -> no push, tdo stays 0; FIFO contents are unchanged.

Source files
------------

// File: rtl/jtag_dr_stream_ctrl.sv
// USER4 DR bridge: turns 8-bit DR scans into a byte stream for the solver
// and returns {status, result} on tdo for host readback.
module jtag_dr_stream_ctrl #(
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    tck,
    input  logic                    test_logic_reset,
    input  logic                    ir_is_user,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic                    tdi,
    output logic                    tdo,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    input  logic [RESULT_WIDTH-1:0] result,
    input  logic                    result_valid,
    output logic                    overflow,
    output logic [5:0]              fifo_level
);

    localparam int W  = RESULT_WIDTH + 8;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              in_sr_q, in_sr_d;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    logic [W-1:0]            out_sr_q, out_sr_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [5:0]              level_q, level_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [7:0]              mem_q [FIFO_DEPTH];

    logic       push;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       drop;
    logic [7:0] status;

    assign status = {overflow_q, done_q, level_q};

    // Scan FSM; leaving USER4 forces IDLE and suppresses any pending push.
    always_comb begin
        state_d   = state_q;
        in_sr_d   = in_sr_q;
        bit_cnt_d = bit_cnt_q;
        out_sr_d  = out_sr_q;
        push      = 1'b0;
        if (!ir_is_user) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (capture_dr) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = 8'd0;
                        out_sr_d  = {status, result_q};
                    end
                end
                ST_SHIFT: begin
                    if (shift_dr) begin
                        in_sr_d  = {tdi, in_sr_q[7:1]};
                        out_sr_d = {tdi, out_sr_q[W-1:1]};
                        if (bit_cnt_q != 8'hFF) begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                    if (update_dr) begin
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    push    = (bit_cnt_q == 8'd8);
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO survives only if the head leaves on the same edge.
    always_comb begin
        pop        = byte_valid & byte_ready;
        full       = (level_q == 6'(FIFO_DEPTH));
        wr_en      = push & (~full | pop);
        drop       = push & full & ~pop;
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            level_d = level_q + 6'd1;
        end else if (!wr_en && pop) begin
            level_d = level_q - 6'd1;
        end
    end

    always_comb begin
        result_d = result_q;
        done_d   = done_q;
        if (result_valid) begin
            result_d = result;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state_q    <= ST_IDLE;
            in_sr_q    <= '0;
            bit_cnt_q  <= '0;
            out_sr_q   <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_sr_q    <= in_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            out_sr_q   <= out_sr_d;
            result_q   <= result_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge tck) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_sr_q;
        end
    end

    assign tdo        = out_sr_q[0];
    assign byte_valid = (level_q != 6'd0);
    assign byte_data  = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_jtag_dr_stream_ctrl.sv
// Randomized bench for jtag_dr_stream_ctrl against a scan-level queue model.
module tb_jtag_dr_stream_ctrl;

    localparam int RW    = 16;
    localparam int DEPTH = 16;

    logic          tck = 1'b0;
    logic          rst;
    logic          ir;
    logic          cap;
    logic          sh;
    logic          upd;
    logic          tdi;
    logic          tdo;
    logic [7:0]    bdata;
    logic          bvalid;
    logic          bready;
    logic [RW-1:0] res;
    logic          rv;
    logic          ovf;
    logic [5:0]    lvl;

    always #5 tck = ~tck;

    jtag_dr_stream_ctrl #(
        .RESULT_WIDTH(RW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .tck             (tck),
        .test_logic_reset(rst),
        .ir_is_user      (ir),
        .capture_dr      (cap),
        .shift_dr        (sh),
        .update_dr       (upd),
        .tdi             (tdi),
        .tdo             (tdo),
        .byte_data       (bdata),
        .byte_valid      (bvalid),
        .byte_ready      (bready),
        .result          (res),
        .result_valid    (rv),
        .overflow        (ovf),
        .fifo_level      (lvl)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs    = 0;

    logic [7:0]    q[$];
    logic          m_ovf;
    logic          m_done;
    logic [RW-1:0] m_res;
    logic [RW+7:0] m_out;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    // Every accepted handshake must deliver the oldest byte the model holds.
    always @(negedge tck) begin
        logic [31:0] e;
        if (!rst && bvalid && bready) begin
            hs++;
            if (q.size() > 0) e = 32'(q.pop_front());
            else e = 32'hDEAD;
            check("pop_data", 32'(bdata), e);
        end
    end

    task automatic chk_state;
        check("level", 32'(lvl), 32'(q.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("valid", 32'(bvalid), 32'(q.size() != 0));
        if (q.size() > 0) check("head", 32'(bdata), 32'(q[0]));
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        cap    = 1'b0;
        sh     = 1'b0;
        upd    = 1'b0;
        tdi    = 1'b0;
        bready = 1'b0;
        rv     = 1'b0;
        #1;
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_valid", 32'(bvalid), 32'd0);
        check("rst_data", 32'(bdata), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_level", 32'(lvl), 32'd0);
        tick;
        rst = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_res  = '0;
        m_out  = '0;
        tick;
    endtask

    task automatic scan(input int n, input logic [31:0] data,
                        output logic [31:0] got);
        logic [31:0] exp;
        logic        b;
        logic        was_empty;
        got = '0;
        exp = '0;
        cap = 1'b1;
        tick;
        cap = 1'b0;
        if (ir) m_out = {m_ovf, m_done, 6'(q.size()), m_res};
        sh = 1'b1;
        for (int i = 0; i < n; i++) begin
            b   = (i < 32) ? data[i[4:0]] : 1'($urandom);
            tdi = b;
            if (i < 32) begin
                got[i[4:0]] = tdo;
                exp[i[4:0]] = m_out[0];
            end
            if (ir) m_out = {b, m_out[RW+7:1]};
            tick;
        end
        sh  = 1'b0;
        tdi = 1'b0;
        check("scan_tdo", got, exp);
        was_empty = (q.size() == 0);
        upd = 1'b1;
        tick;
        upd = 1'b0;
        if (ir && n == 8 && was_empty && !bready)
            check("lat_commit", 32'(bvalid), 32'd0);
        tick;
        if (ir && n == 8) begin
            if (q.size() < DEPTH) q.push_back(data[7:0]);
            else m_ovf = 1'b1;
            if (!bready) check("lat_write", 32'(bvalid), 32'd1);
        end
    endtask

    task automatic drain(input int k, input bit rnd);
        for (int i = 0; i < k; i++) begin
            bready = rnd ? 1'($urandom) : 1'b1;
            tick;
        end
        bready = 1'b0;
        tick;
    endtask

    task automatic pulse_result(input logic [RW-1:0] v);
        res = v;
        rv  = 1'b1;
        tick;
        rv     = 1'b0;
        m_res  = v;
        m_done = 1'b1;
    endtask

    logic [31:0] got;
    int          h0;

    initial begin
        ir  = 1'b1;
        res = '0;
        do_reset;

        bready = 1'b1;
        h0 = hs;
        scan(8, 32'h52, got);
        repeat (3) tick;
        bready = 1'b0;
        tick;
        check("t1_handshakes", 32'(hs - h0), 32'd1);
        chk_state;

        cap = 1'b1;
        tick;
        cap = 1'b0;
        sh  = 1'b1;
        tdi = 1'b1;
        repeat (4) tick;
        do_reset;
        h0 = hs;
        scan(8, 32'h0A, got);
        chk_state;
        drain(4, 1'b0);
        check("t5_handshakes", 32'(hs - h0), 32'd1);
        chk_state;

        do_reset;
        pulse_result(16'h1234);
        scan(16, 32'h0, got);
        check("t3_result", 32'(got[15:0]), 32'h1234);
        chk_state;
        scan(24, 32'h0, got);
        check("t4_status", 32'(got[23:16]), 32'h40);
        chk_state;

        scan(8, 32'h77, got);
        ir = 1'b0;
        scan(8, 32'h33, got);
        ir = 1'b1;
        chk_state;
        scan(264, $urandom, got);
        chk_state;
        drain(4, 1'b0);
        chk_state;

        do_reset;
        for (int v = 0; v <= 16; v++) scan(8, 32'(v), got);
        chk_state;
        check("t2_level", 32'(lvl), 32'd16);
        check("t2_ovf", 32'(ovf), 32'd1);
        drain(20, 1'b0);
        chk_state;

        do_reset;
        for (int it = 0; it < 60; it++) begin
            case ($urandom % 4)
                0, 1:    scan(8, $urandom, got);
                2:       scan($urandom_range(1, 40), $urandom, got);
                default: pulse_result(RW'($urandom));
            endcase
            chk_state;
            if ($urandom % 3 == 0) begin
                drain($urandom_range(1, 8), 1'b1);
                chk_state;
            end
        end
        drain(40, 1'b0);
        chk_state;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
